// File: rtl/ddr_port_arbiter_pkg.sv
// Shared types for the DDR port arbiter slice.
// Request buffers, FSM states and a small modulo helper.
package ddr_port_arbiter_pkg;

  localparam int DDR_ADDR_W = 16;
  localparam int DDR_DATA_W = 32;

  typedef logic [DDR_ADDR_W-1:0] ddr_address_t;
  typedef logic [DDR_DATA_W-1:0] ddr_data_t;

  typedef struct packed {
    ddr_address_t addr;
    ddr_data_t    w_data;
    logic         write;
  } ddr_req_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

  function automatic int wrap_inc(int v, int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/ddr_port_arbiter_if.sv
// Requester-side and DDR-side buses of the port arbiter.
// master: the arbiter; slave: requesters plus DDR controller.
interface ddr_port_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import ddr_port_arbiter_pkg::*;

  ddr_address_t [NUM_REQ-1:0] req_ddr_address_i;
  logic         [NUM_REQ-1:0] req_ddr_w_en_i;
  logic         [NUM_REQ-1:0] req_ddr_r_en_i;
  ddr_data_t    [NUM_REQ-1:0] req_ddr_w_data_i;
  logic         [NUM_REQ-1:0] req_ddr_w_done_o;
  ddr_data_t    [NUM_REQ-1:0] req_ddr_r_data_o;
  logic         [NUM_REQ-1:0] req_ddr_r_valid_o;

  ddr_address_t ddr_address_o;
  logic         ddr_w_en_o;
  logic         ddr_r_en_o;
  ddr_data_t    ddr_w_data_o;
  logic         ddr_w_done_i;
  ddr_data_t    ddr_r_data_i;
  logic         ddr_r_valid_i;

  modport master (
    input  req_ddr_address_i, req_ddr_w_en_i,
    input  req_ddr_r_en_i, req_ddr_w_data_i,
    output req_ddr_w_done_o, req_ddr_r_data_o,
    output req_ddr_r_valid_o,
    output ddr_address_o, ddr_w_en_o,
    output ddr_r_en_o, ddr_w_data_o,
    input  ddr_w_done_i, ddr_r_data_i,
    input  ddr_r_valid_i
  );

  modport slave (
    output req_ddr_address_i, req_ddr_w_en_i,
    output req_ddr_r_en_i, req_ddr_w_data_i,
    input  req_ddr_w_done_o, req_ddr_r_data_o,
    input  req_ddr_r_valid_o,
    input  ddr_address_o, ddr_w_en_o,
    input  ddr_r_en_o, ddr_w_data_o,
    output ddr_w_done_i, ddr_r_data_i,
    output ddr_r_valid_i
  );

endinterface

// File: rtl/ddr_port_arbiter_rr.sv
// Combinational round-robin pick: first request at or after ptr.
// Search wraps modulo NUM_REQ.
module round_robin_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int REQ_IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [REQ_IDX_W-1:0] ptr,
  output logic [NUM_REQ-1:0]   grant,
  output logic [REQ_IDX_W-1:0] grant_idx,
  output logic                 any_grant
);

  logic [REQ_IDX_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(ptr) + i >= NUM_REQ)
        idx = REQ_IDX_W'(int'(ptr) + i - NUM_REQ);
      else
        idx = REQ_IDX_W'(int'(ptr) + i);
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Shares one DDR port among NUM_REQ pulse-style masters.
// One buffered request per master, round-robin grant, one DDR op at a time.
module ddr_port_arbiter
  import ddr_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int REQ_IDX_W = $clog2(NUM_REQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  ddr_port_arbiter_if.master   bus,
  output logic                 busy_o,
  output logic [REQ_IDX_W-1:0] grant_idx_o,
  output logic                 err_o
);

  arb_state_t             state_q, state_d;
  ddr_req_t [NUM_REQ-1:0] pend_q;
  logic     [NUM_REQ-1:0] pend_v_q;
  ddr_req_t               cur_q;
  logic [REQ_IDX_W-1:0]   owner_q, ptr_q;
  logic                   err_q;

  logic [NUM_REQ-1:0]   grant, take, drop;
  logic [REQ_IDX_W-1:0] grant_idx;
  logic                 any_grant, grant_en;
  logic                 resp_ok, resp_bad, err_set;

  round_robin_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .REQ_IDX_W(REQ_IDX_W)
  ) u_rr (
    .req      (pend_v_q),
    .ptr      (ptr_q),
    .grant    (grant),
    .grant_idx(grant_idx),
    .any_grant(any_grant)
  );

  // A master that is buffered or currently owns the port has one outstanding.
  always_comb begin
    take = '0;
    drop = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (bus.req_ddr_w_en_i[k] || bus.req_ddr_r_en_i[k]) begin
        if (pend_v_q[k] ||
            (state_q != IDLE && owner_q == REQ_IDX_W'(k)))
          drop[k] = 1'b1;
        else
          take[k] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    resp_ok  = 1'b0;
    resp_bad = 1'b0;
    bus.ddr_w_en_o        = 1'b0;
    bus.ddr_r_en_o        = 1'b0;
    bus.req_ddr_w_done_o  = '0;
    bus.req_ddr_r_valid_o = '0;
    unique case (state_q)
      IDLE: begin
        resp_bad = bus.ddr_w_done_i | bus.ddr_r_valid_i;
        if (any_grant) begin
          grant_en = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        resp_bad       = bus.ddr_w_done_i | bus.ddr_r_valid_i;
        bus.ddr_w_en_o = cur_q.write;
        bus.ddr_r_en_o = ~cur_q.write;
        state_d        = WAIT;
      end
      WAIT: begin
        resp_ok  = cur_q.write ? bus.ddr_w_done_i : bus.ddr_r_valid_i;
        resp_bad = cur_q.write ? bus.ddr_r_valid_i : bus.ddr_w_done_i;
        bus.req_ddr_w_done_o[owner_q]  = resp_ok & cur_q.write;
        bus.req_ddr_r_valid_o[owner_q] = resp_ok & ~cur_q.write;
        if (resp_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign err_set = (|drop) |
                   (|(bus.req_ddr_w_en_i & bus.req_ddr_r_en_i)) |
                   resp_bad;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q   <= '0;
      pend_v_q <= '0;
      cur_q    <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      pend_v_q <= (pend_v_q & ~({NUM_REQ{grant_en}} & grant)) | take;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (take[k]) begin
          pend_q[k].addr   <= bus.req_ddr_address_i[k];
          pend_q[k].w_data <= bus.req_ddr_w_data_i[k];
          pend_q[k].write  <= bus.req_ddr_w_en_i[k];
        end
      end
      if (grant_en) begin
        owner_q <= grant_idx;
        cur_q   <= pend_q[grant_idx];
        ptr_q   <= REQ_IDX_W'(wrap_inc(int'(grant_idx), NUM_REQ));
      end
      err_q <= err_q | err_set;
    end
  end

  assign bus.ddr_address_o    = cur_q.addr;
  assign bus.ddr_w_data_o     = cur_q.w_data;
  assign bus.req_ddr_r_data_o = {NUM_REQ{bus.ddr_r_data_i}};

  assign busy_o      = (state_q != IDLE) | (|pend_v_q);
  assign grant_idx_o = owner_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Scoreboard bench for ddr_port_arbiter with a latency-randomised DDR model.
// Directed protocol cases followed by random three-master traffic.
module tb_ddr_port_arbiter;
  import ddr_port_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int IW = $clog2(N);

  typedef struct {
    logic         w;
    ddr_address_t addr;
    ddr_data_t    data;
  } exp_t;

  logic          clk;
  logic          rst_i;
  logic          busy;
  logic [IW-1:0] gidx;
  logic          err;

  ddr_port_arbiter_if #(.NUM_REQ(N)) bus();

  ddr_port_arbiter #(.NUM_REQ(N)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .bus        (bus),
    .busy_o     (busy),
    .grant_idx_o(gidx),
    .err_o      (err)
  );

  int n_chk;
  int n_fail;

  exp_t      exp_q [N][$];
  bit        issued [N];
  int        skipped [N];
  int        grants [$];
  ddr_data_t mem [int];
  ddr_data_t shadow [int];

  int           lat_lo = 2;
  int           lat_hi = 6;
  int           ddr_cnt = 0;
  bit           ddr_pw;
  ddr_address_t ddr_a;
  bit           inj_w = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic ddr_data_t init_val(int a);
    return 32'hD000_0000 | 32'(a);
  endfunction

  function automatic ddr_data_t ddr_rd(int a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  function automatic ddr_data_t sh_rd(int a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  function automatic bit pending_any();
    for (int k = 0; k < N; k++)
      if (exp_q[k].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // DDR controller model: fixed one-op-at-a-time memory with random latency.
  initial begin
    bus.ddr_w_done_i  = 1'b0;
    bus.ddr_r_valid_i = 1'b0;
    bus.ddr_r_data_i  = '0;
    forever begin
      @(posedge clk); #1;
      bus.ddr_w_done_i  = 1'b0;
      bus.ddr_r_valid_i = 1'b0;
      if (ddr_cnt > 0) begin
        ddr_cnt--;
        if (ddr_cnt == 0) begin
          if (ddr_pw) bus.ddr_w_done_i = 1'b1;
          else begin
            bus.ddr_r_valid_i = 1'b1;
            bus.ddr_r_data_i  = ddr_rd(int'(ddr_a));
          end
        end
      end
      if (inj_w) begin
        bus.ddr_w_done_i = 1'b1;
        inj_w = 1'b0;
      end
      if (bus.ddr_w_en_o || bus.ddr_r_en_o) begin
        ddr_pw = bus.ddr_w_en_o;
        ddr_a  = bus.ddr_address_o;
        if (ddr_pw) mem[int'(ddr_a)] = bus.ddr_w_data_o;
        ddr_cnt = int'($urandom_range(lat_hi, lat_lo));
      end
    end
  end

  task automatic on_issue();
    int   g;
    exp_t e;
    g = int'(gidx);
    grants.push_back(g);
    check("issue_one_en", bus.ddr_w_en_o & bus.ddr_r_en_o, 0);
    if (exp_q[g].size() == 0 || issued[g]) begin
      n_chk++;
      n_fail++;
      $display("FAIL issue_unexpected: owner %0d issued, expected none", g);
      return;
    end
    e = exp_q[g][0];
    check("issue_write", bus.ddr_w_en_o, e.w);
    check("issue_addr", bus.ddr_address_o, e.addr);
    if (e.w) check("issue_wdata", bus.ddr_w_data_o, e.data);
    issued[g]  = 1'b1;
    skipped[g] = 0;
    for (int k = 0; k < N; k++) begin
      if (k != g && exp_q[k].size() != 0 && !issued[k]) begin
        skipped[k]++;
        check("no_starve", skipped[k] > N, 0);
      end
    end
  endtask

  task automatic on_resp(input int k);
    exp_t e;
    if (exp_q[k].size() == 0 || !issued[k]) begin
      n_chk++;
      n_fail++;
      $display("FAIL resp_unexpected: req %0d got response, expected none", k);
      return;
    end
    e = exp_q[k].pop_front();
    issued[k] = 1'b0;
    check("resp_type_done", bus.req_ddr_w_done_o[k], e.w);
    check("resp_type_valid", bus.req_ddr_r_valid_o[k], !e.w);
    if (e.w) shadow[int'(e.addr)] = e.data;
    else check("read_data", bus.req_ddr_r_data_o[k], sh_rd(int'(e.addr)));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        if (bus.ddr_w_en_o || bus.ddr_r_en_o) on_issue();
        for (int k = 0; k < N; k++)
          if (bus.req_ddr_w_done_o[k] || bus.req_ddr_r_valid_o[k])
            on_resp(k);
      end
    end
  end

  task automatic clear_pulses();
    bus.req_ddr_w_en_i = '0;
    bus.req_ddr_r_en_i = '0;
  endtask

  task automatic drive(input int k, input bit w, input bit r,
                       input ddr_address_t a, input ddr_data_t d,
                       input bit expect_it);
    exp_t e;
    bus.req_ddr_w_en_i[k]    = w;
    bus.req_ddr_r_en_i[k]    = r;
    bus.req_ddr_address_i[k] = a;
    bus.req_ddr_w_data_i[k]  = d;
    if (expect_it) begin
      e.w    = w;
      e.addr = a;
      e.data = d;
      exp_q[k].push_back(e);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    clear_pulses();
    for (int k = 0; k < N; k++) begin
      exp_q[k].delete();
      issued[k]  = 1'b0;
      skipped[k] = 0;
    end
    grants.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int c;
    c = 0;
    while ((pending_any() || ddr_cnt != 0) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    n_chk++;
    if (c >= budget) begin
      n_fail++;
      $display("FAIL %s: drain timeout after %0d cycles, expected idle", name, c);
    end
  endtask

  task automatic run_auto(input logic [N-1:0] mask, input int pct,
                          input int ops, input int budget,
                          input string name);
    int sent;
    int c;
    bit w;
    sent = 0;
    c    = 0;
    while ((sent < ops || pending_any() || ddr_cnt != 0) && c < budget) begin
      for (int k = 0; k < N; k++) begin
        if (mask[k] && exp_q[k].size() == 0 && sent < ops &&
            $urandom_range(99) < pct) begin
          w = 1'($urandom_range(1));
          drive(k, w, !w, ddr_address_t'($urandom_range(7)), $urandom, 1'b1);
          sent++;
        end
      end
      @(posedge clk); #1;
      clear_pulses();
      c++;
    end
    n_chk++;
    if (c >= budget) begin
      n_fail++;
      $display("FAIL %s: timeout with %0d of %0d ops sent", name, sent, ops);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_i  = 1'b1;
    clear_pulses();
    bus.req_ddr_address_i = '0;
    bus.req_ddr_w_data_i  = '0;
    @(posedge clk); #1;
    do_reset();

    @(negedge clk);
    check("rst_w_en", bus.ddr_w_en_o, 0);
    check("rst_r_en", bus.ddr_r_en_o, 0);
    check("rst_addr", bus.ddr_address_o, 0);
    check("rst_wdata", bus.ddr_w_data_o, 0);
    check("rst_done", bus.req_ddr_w_done_o, 0);
    check("rst_valid", bus.req_ddr_r_valid_o, 0);
    check("rst_busy", busy, 0);
    check("rst_gidx", gidx, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1;

    // single read, checking issue latency
    lat_lo = 2;
    lat_hi = 2;
    mem[5]    = 32'hA5;
    shadow[5] = 32'hA5;
    drive(0, 1'b0, 1'b1, 16'd5, '0, 1'b1);
    @(posedge clk); #1;
    clear_pulses();
    @(posedge clk);
    @(negedge clk);
    check("rd_latency_en", bus.ddr_r_en_o, 1);
    check("rd_latency_addr", bus.ddr_address_o, 5);
    @(posedge clk); #1;
    drain("single_read", 50);
    check("rd_err", err, 0);
    check("rd_busy", busy, 0);

    // same-cycle contention: write then read of the same address
    do_reset();
    lat_lo = 2;
    lat_hi = 5;
    drive(0, 1'b1, 1'b0, 16'd3, 32'h1234_5678, 1'b1);
    drive(1, 1'b0, 1'b1, 16'd3, '0, 1'b1);
    @(posedge clk); #1;
    clear_pulses();
    drain("contention", 60);
    check("cont_grants", grants.size(), 2);
    if (grants.size() == 2) begin
      check("cont_first", grants[0], 0);
      check("cont_second", grants[1], 1);
    end

    // fairness: two masters re-request immediately
    do_reset();
    lat_lo = 2;
    lat_hi = 4;
    run_auto(3'b011, 100, 16, 2000, "fairness");
    check("fair_grants", grants.size(), 16);
    foreach (grants[i]) check("fair_alternate", grants[i], i % 2);
    check("fair_err", err, 0);

    // second pulse while the first is still buffered
    do_reset();
    lat_lo = 3;
    lat_hi = 3;
    drive(0, 1'b1, 1'b0, 16'd10, 32'hCAFE_0001, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 16'd11, 32'hDEAD_0002, 1'b0);
    @(posedge clk); #1;
    clear_pulses();
    check("dup_err", err, 1);
    drain("dup", 40);
    check("dup_dropped", mem.exists(11), 0);
    check("dup_grants", grants.size(), 1);

    // w_en and r_en together: write kept
    do_reset();
    check("dual_err_clear", err, 0);
    drive(1, 1'b1, 1'b1, 16'd20, 32'hBEEF_0003, 1'b1);
    @(posedge clk); #1;
    clear_pulses();
    check("dual_err", err, 1);
    drain("dual", 40);
    check("dual_grants", grants.size(), 1);

    // spurious DDR completion while idle
    do_reset();
    inj_w = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("spur_err", err, 1);
    check("spur_busy", busy, 0);

    // reset while waiting; the late response must not be forwarded
    do_reset();
    lat_lo = 6;
    lat_hi = 6;
    drive(0, 1'b0, 1'b1, 16'd5, '0, 1'b1);
    @(posedge clk); #1;
    clear_pulses();
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_reset();
    check("midrst_err_clear", err, 0);
    check("midrst_busy", busy, 0);
    drain("midrst", 20);
    @(posedge clk); #1;
    check("midrst_late_err", err, 1);
    check("midrst_late_busy", busy, 0);

    // random three-master traffic
    do_reset();
    lat_lo = 2;
    lat_hi = 6;
    run_auto(3'b111, 40, 200, 20000, "random");
    check("rand_grants", grants.size(), 200);
    check("rand_err", err, 0);
    check("rand_busy", busy, 0);
    for (int k = 0; k < N; k++) check("rand_queue_empty", exp_q[k].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
